program_fetch_unit: RTL and testbench

Fetch stage directly upstream of the 2K x 14 program ROM. Owns the 11-bit program counter, drives the ROM address, and registers the returned 14-bit instruction into the instruction register for the execute stage. Implements GOTO/CALL/RETURN redirection with an 8-level hardware return stack and inserts NOP bubbles for skips and redirects.

---
 rtl/pic_pkg.sv | 22 ++
 rtl/program_fetch_unit_if.sv | 32 +++
 rtl/return_stack.sv | 58 +++++
 rtl/program_fetch_unit.sv | 81 ++++++++
 tb/tb_program_fetch_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the program fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_pkg;

  localparam int ADDR_W      = 11;
  localparam int INSTR_W     = 14;
  localparam int STACK_DEPTH = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR    = 14'h0000;
  localparam logic [ADDR_W-1:0]  RESET_VECTOR = 11'h000;

  // Redirect/skip requests coming back from the execute stage.
  typedef struct packed {
    logic              jump_en;
    logic              call_en;
    logic              ret_en;
    logic              skip_en;
    logic [ADDR_W-1:0] jump_addr;
  } fetch_ctrl_t;

endpackage

// File: rtl/program_fetch_unit_if.sv
// Fetch-stage bundle: ROM address/data, IR to execute, redirect controls, stack flags.
// Latency: n/a (wiring only).
// Backpressure: stall from execute freezes the whole fetch stage.
interface program_fetch_unit_if;

  logic                        stall;
  logic [pic_pkg::ADDR_W-1:0]  rom_addr_out;
  logic [pic_pkg::INSTR_W-1:0] rom_data_in;
  logic [pic_pkg::INSTR_W-1:0] ir_out;
  logic [pic_pkg::ADDR_W-1:0]  ir_pc;
  logic                        ir_valid;
  logic                        jump_en;
  logic                        call_en;
  logic                        ret_en;
  logic [pic_pkg::ADDR_W-1:0]  jump_addr;
  logic                        skip_en;
  logic                        stack_overflow;
  logic                        stack_underflow;

  // Fetch unit side.
  modport master (
    input  stall, rom_data_in, jump_en, call_en, ret_en, jump_addr, skip_en,
    output rom_addr_out, ir_out, ir_pc, ir_valid, stack_overflow, stack_underflow
  );

  // ROM / execute-stage side.
  modport slave (
    output stall, rom_data_in, jump_en, call_en, ret_en, jump_addr, skip_en,
    input  rom_addr_out, ir_out, ir_pc, ir_valid, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/return_stack.sv
// Circular hardware return stack with occupancy tracking and sticky over/underflow flags.
// Latency: pop data is combinational from the current pointer; push/pop update on the clock edge.
// Backpressure: none; a full push overwrites the oldest entry, an empty pop returns stale data.
module return_stack
  import pic_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic [OCC_W-1:0] occ_q;
  logic             overflow_q;
  logic             underflow_q;

  // sp addresses the next free slot, so the top of stack lives one below it.
  assign data_out  = mem[sp - PTR_W'(1)];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Storage is not reset; only the pointer and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= data_in;
  end

  // Pointer, occupancy and sticky flags; push and pop are never both requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp          <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push) begin
      sp <= sp + PTR_W'(1);
      if (occ_q == OCC_FULL) overflow_q <= 1'b1;
      else                   occ_q      <= occ_q + OCC_W'(1);
    end else if (pop) begin
      sp <= sp - PTR_W'(1);
      if (occ_q == '0) underflow_q <= 1'b1;
      else             occ_q       <= occ_q - OCC_W'(1);
    end
  end

endmodule

// File: rtl/program_fetch_unit.sv
// Fetch stage: owns the PC, addresses the program ROM and registers the instruction for execute.
// Latency: one cycle from ROM address to ir_out; redirects and skips insert a single NOP bubble.
// Backpressure: stall holds PC, IR, stack and flags; redirect/skip inputs are ignored while stalled.
module program_fetch_unit
  import pic_pkg::*;
(
  input  logic clk,
  input  logic reset,
  program_fetch_unit_if.master bus
);

  fetch_ctrl_t        ctrl;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic [ADDR_W-1:0]  stack_top;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               ir_valid_q;
  logic               redirect;
  logic               push;
  logic               pop;

  assign ctrl = '{jump_en:   bus.jump_en,
                  call_en:   bus.call_en,
                  ret_en:    bus.ret_en,
                  skip_en:   bus.skip_en,
                  jump_addr: bus.jump_addr};

  // Return beats jump; a CALL only pushes when it actually takes the jump.
  assign redirect = ctrl.ret_en | ctrl.jump_en;
  assign push     = ~bus.stall & ctrl.jump_en & ctrl.call_en & ~ctrl.ret_en;
  assign pop      = ~bus.stall & ctrl.ret_en;

  // Next-PC select: return address, then jump target, then sequential (wraps at 2K).
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    if (ctrl.ret_en)       next_pc = stack_top;
    else if (ctrl.jump_en) next_pc = ctrl.jump_addr;
  end

  // PC and instruction register; the word fetched alongside a redirect or skip is squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      ir_q       <= NOP_INSTR;
      ir_pc_q    <= RESET_VECTOR;
      ir_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc      <= next_pc;
      ir_pc_q <= pc;
      if (redirect || ctrl.skip_en) begin
        ir_q       <= NOP_INSTR;
        ir_valid_q <= 1'b0;
      end else begin
        ir_q       <= bus.rom_data_in;
        ir_valid_q <= 1'b1;
      end
    end
  end

  // The pushed return address is the current PC, i.e. the word after the CALL.
  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (pc),
    .data_out  (stack_top),
    .overflow  (bus.stack_overflow),
    .underflow (bus.stack_underflow)
  );

  assign bus.rom_addr_out = pc;
  assign bus.ir_out       = ir_q;
  assign bus.ir_pc        = ir_pc_q;
  assign bus.ir_valid     = ir_valid_q;

endmodule

// File: tb/tb_program_fetch_unit.sv
// Scoreboard bench for program_fetch_unit: directed steps push hand-computed expectations,
// a monitor pops one entry per clock edge and compares IR, PC, flags and stack occupancy.
// Reset values and asynchronous reset are checked inline.
module tb_program_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_fetch_unit_if bus ();

  program_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // ROM model: three fixed words at the reset vector, a recognisable pattern elsewhere.
  function automatic logic [13:0] rw(input logic [10:0] a);
    case (a)
      11'h000: rw = 14'h3003;
      11'h001: rw = 14'h01A5;
      11'h002: rw = 14'h000B;
      default: rw = 14'h2000 | {3'b000, a};
    endcase
  endfunction

  assign bus.rom_data_in = rw(bus.rom_addr_out);

  typedef struct {
    logic [13:0] ir;
    logic [10:0] irpc;
    logic        v;
    logic [10:0] pc;
    logic        ovf;
    logic        udf;
    logic [3:0]  occ;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic       e_ovf = 1'b0;
  logic       e_udf = 1'b0;
  logic [3:0] e_occ = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expectation describes the state right after that edge.
  task automatic step(input logic st, input logic jp, input logic cl, input logic rt,
                      input logic sk, input logic [10:0] ja,
                      input logic [13:0] eir, input logic [10:0] eirpc,
                      input logic ev, input logic [10:0] epc);
    exp_t e;
    bus.stall     = st;
    bus.jump_en   = jp;
    bus.call_en   = cl;
    bus.ret_en    = rt;
    bus.skip_en   = sk;
    bus.jump_addr = ja;
    e.ir = eir; e.irpc = eirpc; e.v = ev; e.pc = epc;
    e.ovf = e_ovf; e.udf = e_udf; e.occ = e_occ;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic plain(input logic [13:0] eir, input logic [10:0] eirpc, input logic [10:0] epc);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, eir, eirpc, 1'b1, epc);
  endtask

  // Monitor: compares the DUT against the oldest expectation shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (mon_en && sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ir_out",          32'(bus.ir_out),          32'(e.ir));
      chk("ir_pc",           32'(bus.ir_pc),           32'(e.irpc));
      chk("ir_valid",        32'(bus.ir_valid),        32'(e.v));
      chk("rom_addr_out",    32'(bus.rom_addr_out),    32'(e.pc));
      chk("stack_overflow",  32'(bus.stack_overflow),  32'(e.ovf));
      chk("stack_underflow", 32'(bus.stack_underflow), 32'(e.udf));
      chk("occupancy",       32'(dut.u_stack.occ_q),   32'(e.occ));
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    32'(bus.rom_addr_out),    32'h0);
    chk({tag, "_ir"},    32'(bus.ir_out),          32'h0);
    chk({tag, "_irpc"},  32'(bus.ir_pc),           32'h0);
    chk({tag, "_valid"}, 32'(bus.ir_valid),        32'h0);
    chk({tag, "_occ"},   32'(dut.u_stack.occ_q),   32'h0);
    chk({tag, "_ovf"},   32'(bus.stack_overflow),  32'h0);
    chk({tag, "_udf"},   32'(bus.stack_underflow), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] cur;
    logic [10:0] tgt;
    logic [10:0] rets [9];
    rets = '{11'h170, 11'h160, 11'h150, 11'h140, 11'h130, 11'h120, 11'h110, 11'h100, 11'h170};

    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.call_en = 1'b0;
    bus.ret_en = 1'b0; bus.skip_en = 1'b0; bus.jump_addr = '0;

    // Reset held across several edges.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Sequential fetch from the reset vector.
    plain(14'h3003, 11'h000, 11'h001);
    plain(14'h01A5, 11'h001, 11'h002);
    plain(14'h000B, 11'h002, 11'h003);
    plain(rw(11'h003), 11'h003, 11'h004);

    // GOTO 0x009 from PC 0x004: bubble, then fetch resumes at the target.
    step(0, 1, 0, 0, 0, 11'h009, 14'h0000, 11'h004, 1'b0, 11'h009);
    plain(rw(11'h009), 11'h009, 11'h00A);

    // Get to 0x002, CALL 0x0A0 from there (PC=0x003), then RETURN.
    step(0, 1, 0, 0, 0, 11'h002, 14'h0000, 11'h00A, 1'b0, 11'h002);
    plain(14'h000B, 11'h002, 11'h003);
    e_occ = 4'd1;
    step(0, 1, 1, 0, 0, 11'h0A0, 14'h0000, 11'h003, 1'b0, 11'h0A0);
    plain(rw(11'h0A0), 11'h0A0, 11'h0A1);
    e_occ = 4'd0;
    step(0, 0, 0, 1, 0, 11'h000, 14'h0000, 11'h0A1, 1'b0, 11'h003);
    plain(rw(11'h003), 11'h003, 11'h004);

    // Nine nested CALLs: pushes 0x004, 0x100..0x170; the ninth overflows.
    cur = 11'h004;
    for (int k = 0; k < 9; k++) begin
      tgt   = 11'h100 + 11'(k * 16);
      e_occ = (k >= 7) ? 4'd8 : 4'(k + 1);
      if (k == 8) e_ovf = 1'b1;
      step(0, 1, 1, 0, 0, tgt, 14'h0000, cur, 1'b0, tgt);
      cur = tgt;
    end

    // Nine RETURNs: eight most recent return addresses, then a stale one with underflow.
    for (int k = 0; k < 9; k++) begin
      e_occ = (k < 8) ? 4'(7 - k) : 4'd0;
      if (k == 8) e_udf = 1'b1;
      step(0, 0, 0, 1, 0, 11'h000, 14'h0000, cur, 1'b0, rets[k]);
      cur = rets[k];
    end

    // PC wrap from 0x7FF to 0x000.
    step(0, 1, 0, 0, 0, 11'h7FF, 14'h0000, 11'h170, 1'b0, 11'h7FF);
    plain(rw(11'h7FF), 11'h7FF, 11'h000);
    plain(14'h3003, 11'h000, 11'h001);

    // Skip at 0x010: bubble, PC advances to 0x011 without redirect.
    step(0, 1, 0, 0, 0, 11'h010, 14'h0000, 11'h001, 1'b0, 11'h010);
    step(0, 0, 0, 0, 1, 11'h000, 14'h0000, 11'h010, 1'b0, 11'h011);
    plain(rw(11'h011), 11'h011, 11'h012);

    // Stall for three cycles with a jump pending: everything holds.
    repeat (3) step(1, 1, 0, 0, 0, 11'h055, rw(11'h011), 11'h011, 1'b1, 11'h012);
    plain(rw(11'h012), 11'h012, 11'h013);

    // CALL then RETURN+CALL+jump together: return wins, no push.
    e_occ = 4'd1;
    step(0, 1, 1, 0, 0, 11'h200, 14'h0000, 11'h013, 1'b0, 11'h200);
    e_occ = 4'd0;
    step(0, 1, 1, 1, 0, 11'h300, 14'h0000, 11'h200, 1'b0, 11'h013);
    // call_en without jump_en is ignored.
    step(0, 0, 1, 0, 0, 11'h000, rw(11'h013), 11'h013, 1'b1, 11'h014);

    // Asynchronous reset in the middle of a CALL cycle.
    mon_en        = 1'b0;
    bus.jump_en   = 1'b1;
    bus.call_en   = 1'b1;
    bus.jump_addr = 11'h400;
    #3;
    reset = 1'b1;
    #1;
    chk_reset_state("async_reset");
    bus.jump_en = 1'b0;
    bus.call_en = 1'b0;
    @(posedge clk);
    #2;
    reset  = 1'b0;
    e_ovf  = 1'b0;
    e_udf  = 1'b0;
    e_occ  = 4'd0;
    mon_en = 1'b1;
    plain(14'h3003, 11'h000, 11'h001);
    plain(14'h01A5, 11'h001, 11'h002);

    @(posedge clk);
    #3;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
